// File: rtl/grayscale_stream_if.sv
// FIFO-side handshake bundle for grayscale_stream: FWFT input FIFO pop side
// plus output FIFO push side. W is the colour channel width.
interface grayscale_stream_if #(
  parameter int W = 8
) ();

  logic           in_rd_en;
  logic           in_empty;
  logic [3*W-1:0] in_dout;
  logic           out_wr_en;
  logic           out_full;
  logic [W-1:0]   out_din;

  // Converter side: pops the input FIFO and pushes the output FIFO.
  modport slave (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  // Environment side: owns both FIFOs.
  modport master (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );

endinterface

// File: rtl/grayscale_stream.sv
// Streaming RGB to single-channel converter. Two-stage stall-able pipeline:
// stage 1 holds the popped pixel and its mode, stage 2 holds the result.
// The two valid bits are the whole control state.
module grayscale_stream #(
  parameter int COLOR_WIDTH = 8,
  parameter int RGB_ORDER   = 1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             mode,
  grayscale_stream_if.slave      bus,
  output logic [COUNT_WIDTH-1:0] pixel_count
);

  localparam int W = COLOR_WIDTH;

  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_LUMA  = 2'd1,
    MODE_MAX   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_t;

  logic [W-1:0] r_in, g_in, b_in;
  logic [W-1:0] r1, g1, b1;
  mode_t        mode1;
  logic         v1;
  logic [W-1:0] y2;
  logic         v2;

  logic         load1, load2, wr;

  logic [W+1:0] sum3;
  logic [W-1:0] avg;
  logic [W+9:0] luma_sum;
  logic [W-1:0] luma;
  logic [W-1:0] max_rg, max_rgb;
  logic [W-1:0] y_next;

  // Channel unpack; RGB_ORDER=0 swaps the R and B fields.
  assign g_in = bus.in_dout[2*W-1:W];
  assign r_in = (RGB_ORDER != 0) ? bus.in_dout[3*W-1:2*W] : bus.in_dout[W-1:0];
  assign b_in = (RGB_ORDER != 0) ? bus.in_dout[W-1:0]     : bus.in_dout[3*W-1:2*W];

  // Handshake. reset gates the pop strobe so nothing is popped while held in
  // reset, even when the input FIFO already presents data.
  assign load2         = v1 && (!v2 || !bus.out_full);
  assign load1         = reset && !bus.in_empty && (!v1 || load2);
  assign wr            = v2 && !bus.out_full;
  assign bus.in_rd_en  = load1;
  assign bus.out_wr_en = wr;
  assign bus.out_din   = y2;

  // Conversion of the stage-1 pixel according to its captured mode.
  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    sum3     = {2'b00, r1} + {2'b00, g1} + {2'b00, b1};
    avg      = W'(sum3 / (W+2)'(3));
    luma_sum = (W+10)'(r1) * (W+10)'(77)
             + (W+10)'(g1) * (W+10)'(150)
             + (W+10)'(b1) * (W+10)'(29);
    luma     = W'(luma_sum >> 8);
    max_rg   = (r1 > g1) ? r1 : g1;
    max_rgb  = (max_rg > b1) ? max_rg : b1;
    y_next   = g1;
    case (mode1)
      MODE_AVG:   y_next = avg;
      MODE_LUMA:  y_next = luma;
      MODE_MAX:   y_next = max_rgb;
      MODE_GREEN: y_next = g1;
      default:    y_next = g1;
    endcase
  end

  // Pipeline registers: stage 1 fills on pop, stage 2 on advance.
  // NOTE: non-blocking assignments make all stages update from pre-edge values, so both stages shift together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1    <= '0;
      g1    <= '0;
      b1    <= '0;
      mode1 <= MODE_AVG;
      v1    <= 1'b0;
      y2    <= '0;
      v2    <= 1'b0;
    end else begin
      if (load1) begin
        r1    <= r_in;
        g1    <= g_in;
        b1    <= b_in;
        mode1 <= mode_t'(mode);
        v1    <= 1'b1;
      end else if (load2) begin
        v1    <= 1'b0;
      end

      if (load2) begin
        y2 <= y_next;
        v2 <= 1'b1;
      end else if (wr) begin
        v2 <= 1'b0;
      end
    end
  end

  // Count of pixels pushed to the output FIFO; wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
    end else if (wr) begin
      pixel_count <= pixel_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_grayscale_stream.sv
// Directed bench for grayscale_stream (W=8, RGB order 1, 4-bit pixel counter).
// A queue models the FWFT input FIFO; outputs are collected on write strobes.
module tb_grayscale_stream;

  typedef struct {
    logic [23:0] pix;
    logic [1:0]  mode;
  } px_t;

  logic       clock;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] pixel_count;

  grayscale_stream_if #(.W(8)) bus ();

  grayscale_stream #(
    .COLOR_WIDTH(8),
    .RGB_ORDER  (1),
    .COUNT_WIDTH(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .bus        (bus),
    .pixel_count(pixel_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  px_t        src[$];
  logic [7:0] got[$];
  int         pcyc[$];
  int         wcyc[$];
  logic [3:0] cnt_at_wr[$];
  int         cyc = 0;
  int         full_from = 0;
  int         full_to = 0;
  int         pops_full = 0;
  int         wr_full = 0;
  int         viol = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic px_t mk(input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input logic [1:0] m);
    px_t p;
    p.pix  = {r, g, b};
    p.mode = m;
    return p;
  endfunction

  // Present the head of the source queue and the output-full schedule.
  task automatic apply();
    bus.out_full = (cyc >= full_from) && (cyc < full_to);
    bus.in_empty = (src.size() == 0);
    bus.in_dout  = (src.size() != 0) ? src[0].pix : 24'h0;
    if (src.size() != 0) mode = src[0].mode;
  endtask

  // One clock: observe strobes at the falling edge, update inputs after rise.
  task automatic cycle();
    logic rd, wr;
    px_t  dummy;
    @(negedge clock);
    rd = bus.in_rd_en;
    wr = bus.out_wr_en;
    if (rd && bus.in_empty) viol++;
    if (wr && bus.out_full) viol++;
    if (bus.out_full) begin
      if (rd) pops_full++;
      if (wr) wr_full++;
    end
    if (rd) pcyc.push_back(cyc);
    if (wr) begin
      got.push_back(bus.out_din);
      wcyc.push_back(cyc);
      cnt_at_wr.push_back(pixel_count);
    end
    @(posedge clock);
    #1;
    if (rd && src.size() != 0) dummy = src.pop_front();
    cyc++;
    apply();
  endtask

  // Run until n outputs arrive (bounded), idle a little, then require exactly n.
  task automatic run(input string tag, input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
    check(tag, got.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src.delete();
    got.delete();
    pcyc.delete();
    wcyc.delete();
    cnt_at_wr.delete();
    full_from = 0;
    full_to   = 0;
    pops_full = 0;
    wr_full   = 0;
    apply();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc++;
    apply();
  endtask

  initial begin
    px_t dummy;
    reset = 1'b1;
    mode  = 2'd0;
    bus.out_full = 1'b0;
    bus.in_empty = 1'b1;
    bus.in_dout  = 24'h0;
    #1;
    reset = 1'b0;
    // Reset state, with the input FIFO already offering a pixel.
    src.push_back(mk(8'h11, 8'h22, 8'h33, 2'd0));
    apply();
    #2;
    check("rst_rd_en", bus.in_rd_en, 0);
    check("rst_wr_en", bus.out_wr_en, 0);
    check("rst_dout", bus.out_din, 0);
    check("rst_count", pixel_count, 0);

    // Mode 0, back-to-back.
    do_reset();
    src.push_back(mk(8'hFF, 8'hFF, 8'hFF, 2'd0));
    src.push_back(mk(8'h01, 8'h01, 8'h00, 2'd0));
    apply();
    run("avg_n", 2, 20);
    if (got.size() == 2) begin
      check("avg_ff", got[0], 8'hFF);
      check("avg_00", got[1], 8'h00);
      check("latency", wcyc[0] - pcyc[0], 2);
      check("back2back", wcyc[1] - wcyc[0], 1);
    end
    check("avg_count", pixel_count, 2);

    // Mode 1 luma.
    do_reset();
    src.push_back(mk(8'd100, 8'd50, 8'd25, 2'd1));
    src.push_back(mk(8'hFF, 8'hFF, 8'hFF, 2'd1));
    src.push_back(mk(8'h00, 8'h00, 8'h00, 2'd1));
    apply();
    run("luma_n", 3, 20);
    if (got.size() == 3) begin
      check("luma_62", got[0], 8'h3E);
      check("luma_ff", got[1], 8'hFF);
      check("luma_00", got[2], 8'h00);
    end

    // Per-pixel mode switching.
    do_reset();
    src.push_back(mk(8'd10, 8'd200, 8'd30, 2'd2));
    src.push_back(mk(8'd10, 8'd200, 8'd30, 2'd3));
    src.push_back(mk(8'd10, 8'd90,  8'd30, 2'd2));
    src.push_back(mk(8'd10, 8'd90,  8'd30, 2'd0));
    apply();
    run("sw_n", 4, 20);
    if (got.size() == 4) begin
      check("sw_max200", got[0], 8'd200);
      check("sw_g200", got[1], 8'd200);
      check("sw_max90", got[2], 8'd90);
      check("sw_avg43", got[3], 8'd43);
    end

    // Backpressure: output full for the first 5 cycles of a 10-pixel burst.
    do_reset();
    for (int i = 0; i < 10; i++) src.push_back(mk(8'h55, 8'(8'h10 + i * 3), 8'hAA, 2'd3));
    full_from = cyc;
    full_to   = cyc + 5;
    apply();
    run("bp_n", 10, 60);
    check("bp_pops_full", pops_full, 2);
    check("bp_wr_full", wr_full, 0);
    if (got.size() == 10) begin
      check("bp_resume", wcyc[0], full_to);
      for (int i = 0; i < 10; i++) check($sformatf("bp_order%0d", i), got[i], 8'(8'h10 + i * 3));
    end
    check("bp_count", pixel_count, 10);

    // Reset mid-burst with both stages valid; counter currently reads 10.
    for (int i = 0; i < 4; i++) src.push_back(mk(8'h00, 8'(8'hA0 + i), 8'h00, 2'd3));
    full_from = cyc;
    full_to   = cyc + 100;
    apply();
    cycle();
    cycle();
    full_to = 0;
    apply();
    #1;
    reset = 1'b0;
    #1;
    check("mid_rd_en", bus.in_rd_en, 0);
    check("mid_wr_en", bus.out_wr_en, 0);
    check("mid_dout", bus.out_din, 0);
    check("mid_count", pixel_count, 0);
    src.delete();
    got.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc++;
    apply();
    src.push_back(mk(8'd100, 8'd50, 8'd25, 2'd1));
    src.push_back(mk(8'hFF, 8'hFF, 8'hFF, 2'd0));
    apply();
    run("post_n", 2, 20);
    if (got.size() == 2) begin
      check("post_luma", got[0], 8'h3E);
      check("post_avg", got[1], 8'hFF);
    end

    // Counter wrap on a 4-bit counter: 17 writes.
    do_reset();
    for (int i = 0; i < 17; i++) src.push_back(mk(8'h00, 8'(i), 8'h00, 2'd3));
    apply();
    run("wrap_n", 17, 60);
    if (got.size() == 17) begin
      check("wrap_15", cnt_at_wr[15], 15);
      check("wrap_0", cnt_at_wr[16], 0);
      check("wrap_last_px", got[16], 8'd16);
    end
    check("wrap_1", pixel_count, 1);

    check("protocol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
